// File: rtl/strassen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : strassen_pkg
// Description : Shared constants for the Strassen 2x2 loader and control FSM:
//               default widths, operand element indices, loader state
//               encoding and ALU opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package strassen_pkg;

    // Default element and operand-memory address widths
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int N_OPS_2X2  = 8;

    // Operand bank element positions (A11 occupies the LSBs of the bank)
    localparam int IDX_A11 = 0;
    localparam int IDX_A12 = 1;
    localparam int IDX_A21 = 2;
    localparam int IDX_A22 = 3;
    localparam int IDX_B11 = 4;
    localparam int IDX_B12 = 5;
    localparam int IDX_B21 = 6;
    localparam int IDX_B22 = 7;

    // Loader state encoding
    typedef logic [1:0] ld_state_t;
    localparam ld_state_t ST_IDLE  = 2'd0;
    localparam ld_state_t ST_READ  = 2'd1;
    localparam ld_state_t ST_DRAIN = 2'd2;
    localparam ld_state_t ST_VALID = 2'd3;

    // ALU opcodes shared with the control FSM
    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MULT = 2'd2
    } alu_op_t;

endpackage : strassen_pkg
`default_nettype wire

// File: rtl/strassen_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : strassen_operand_loader
// Description : Fetches the eight 2x2 Strassen operands (A11..B22) from
//               operand memory, one read per cycle, into a parallel bank and
//               holds the bank stable behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module strassen_operand_loader
    import strassen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_OPS  = N_OPS_2X2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    mem_re,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [N_OPS*DATA_W-1:0] ops,
    output logic                    ops_valid,
    input  logic                    ops_ready,
    output logic                    busy
);

    localparam int                  CNT_W      = $clog2(N_OPS);
    localparam logic [CNT_W-1:0]    c_last_idx = CNT_W'(N_OPS - 1);
    localparam logic [CNT_W-1:0]    c_one      = CNT_W'(1);

    ld_state_t          r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_issue;
    logic [CNT_W-1:0]   r_cap;
    logic               r_re_d;
    logic               r_valid;
    logic [DATA_W-1:0]  r_bank [N_OPS];

    // Read port is driven straight from the state so the 8 issues are back to back
    always_comb begin
        mem_re   = (r_state == ST_READ);
        mem_addr = '0;
        if (r_state == ST_READ) begin
            mem_addr = r_base + ADDR_W'(r_issue);   // wraps mod 2^ADDR_W
        end
        busy      = (r_state != ST_IDLE);
        ops_valid = r_valid;
    end

    // Load sequencer: IDLE -> READ (8 issues) -> DRAIN (last word lands) -> VALID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_issue <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_issue <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_issue <= r_issue + c_one;
                    if (r_issue == c_last_idx) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_VALID;
                    r_valid <= 1'b1;
                end
                ST_VALID: begin
                    if (r_valid && ops_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture path: data returns one cycle after its issue; a reset drops any
    // read still in flight by clearing the delayed read-enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_re_d <= 1'b0;
            r_cap  <= '0;
            for (int k = 0; k < N_OPS; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            r_re_d <= mem_re;
            if (r_re_d) begin
                r_bank[r_cap] <= mem_rdata;
                r_cap         <= r_cap + c_one;   // wraps to 0 after the 8th word
            end
        end
    end

    // Flatten the bank, element 0 (A11) in the LSBs
    generate
        for (genvar g = 0; g < N_OPS; g++) begin : g_ops
            assign ops[g*DATA_W +: DATA_W] = r_bank[g];
        end
    endgenerate

endmodule : strassen_operand_loader
`default_nettype wire

// File: tb/tb_strassen_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_strassen_operand_loader
// Description : Self-checking bench for strassen_operand_loader with a
//               one-cycle-latency operand memory model and a scoreboard of
//               expected read addresses and operand banks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strassen_operand_loader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic           mem_re;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_rdata;
    logic [NO*DW-1:0] ops;
    logic           ops_valid;
    logic           ops_ready = 1'b0;
    logic           busy;

    logic [DW-1:0]  mem [16];

    int n_pass  = 0;
    int n_total = 0;

    logic [AW-1:0]    exp_addr_q[$];
    logic [NO*DW-1:0] exp_ops_q[$];
    int  lat, nre, first_re, last_re, addr_err;
    time t_start;

    strassen_operand_loader #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .N_OPS  (NO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .ops       (ops),
        .ops_valid (ops_valid),
        .ops_ready (ops_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Operand memory: read data valid one cycle after the request
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: expected addresses and resulting bank for a load at base
    task automatic push_expected(input logic [AW-1:0] base);
        logic [AW-1:0]    a;
        logic [NO*DW-1:0] e;
        e = '0;
        for (int k = 0; k < NO; k++) begin
            a = base + AW'(k);
            exp_addr_q.push_back(a);
            e[k*DW +: DW] = mem[a];
        end
        exp_ops_q.push_back(e);
    endtask

    // Pulse start, then follow the load until ops_valid (bounded); observed
    // addresses are popped against the scoreboard as they appear
    task automatic run_load(input logic [AW-1:0] base);
        logic [AW-1:0] e;
        nre = 0; first_re = -1; last_re = -1; lat = -1; addr_err = 0;
        base_addr = base;
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (ops_valid) begin
                lat = k;
                break;
            end
            if (mem_re) begin
                if (exp_addr_q.size() > 0) begin
                    e = exp_addr_q.pop_front();
                    if (mem_addr !== e) addr_err++;
                end else begin
                    addr_err++;
                end
                nre++;
                if (first_re < 0) first_re = k;
                last_re = k;
            end
            step();
        end
        addr_err += exp_addr_q.size();
        exp_addr_q.delete();
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        step();
        step();
        n_total++; if (ops !== '0)      $display("FAIL reset_ops: got %h want 0", ops);             else n_pass++;
        n_total++; if (ops_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ops_valid); else n_pass++;
        n_total++; if (mem_re !== 1'b0) $display("FAIL reset_mem_re: got %b want 0", mem_re);      else n_pass++;
        n_total++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr);  else n_pass++;
        n_total++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy);          else n_pass++;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ops !== '0 || ops_valid !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        n_total++; if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_basic();
        logic [NO*DW-1:0] e;
        for (int a = 0; a < 16; a++) mem[a] = (a < 8) ? DW'(8'h10 + a) : 8'hEE;
        push_expected(4'd0);
        run_load(4'd0);
        e = exp_ops_q.pop_front();
        n_total++; if (lat !== 10)     $display("FAIL basic_latency: got %0d want 10", lat);        else n_pass++;
        n_total++; if (nre !== 8 || first_re !== 1 || last_re !== 8)
                       $display("FAIL basic_re_window: got n=%0d first=%0d last=%0d want 8/1/8", nre, first_re, last_re);
                   else n_pass++;
        n_total++; if (addr_err !== 0) $display("FAIL basic_addrs: got %0d errors want 0", addr_err); else n_pass++;
        n_total++; if (ops !== e)      $display("FAIL basic_ops: got %h want %h", ops, e);          else n_pass++;
        n_total++; if (busy !== 1'b1)  $display("FAIL basic_busy_valid: got %b want 1", busy);      else n_pass++;
        ops_ready = 1'b1;
        step();
        ops_ready = 1'b0;
        n_total++; if (ops_valid !== 1'b0 || busy !== 1'b0)
                       $display("FAIL basic_accept: got valid=%b busy=%b want 0/0", ops_valid, busy);
                   else n_pass++;
        step();
        step();
        n_total++; if (ops !== 64'h17161514_13121110) $display("FAIL basic_hold: got %h want 1716151413121110", ops); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 16; a++) mem[a] = DW'(a);
        push_expected(4'd14);
        run_load(4'd14);
        void'(exp_ops_q.pop_front());
        n_total++; if (lat !== 10)     $display("FAIL wrap_latency: got %0d want 10", lat);         else n_pass++;
        n_total++; if (addr_err !== 0) $display("FAIL wrap_addrs: got %0d errors want 0", addr_err); else n_pass++;
        n_total++; if (ops !== 64'h05040302_01000F0E) $display("FAIL wrap_ops: got %h want 0504030201000f0e", ops); else n_pass++;
        ops_ready = 1'b1;
        step();
        ops_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [NO*DW-1:0] e;
        int bad, extra;
        for (int a = 0; a < 16; a++) mem[a] = DW'(8'hA0 + a);
        push_expected(4'd5);
        run_load(4'd5);
        e = exp_ops_q.pop_front();
        n_total++; if (ops !== e) $display("FAIL bp_ops: got %h want %h", ops, e); else n_pass++;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (ops !== e || ops_valid !== 1'b1 || mem_re !== 1'b0 || busy !== 1'b1) bad++;
            start     = (i == 6);
            base_addr = 4'd9;
            step();
        end
        start = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles want 0", bad); else n_pass++;
        ops_ready = 1'b1;
        start     = 1'b1;
        step();
        ops_ready = 1'b0;
        start     = 1'b0;
        n_total++; if (ops_valid !== 1'b0 || busy !== 1'b0)
                       $display("FAIL bp_accept: got valid=%b busy=%b want 0/0", ops_valid, busy);
                   else n_pass++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_re !== 1'b0 || busy !== 1'b0 || ops !== e) extra++;
            step();
        end
        n_total++; if (extra !== 0) $display("FAIL bp_no_queue: got %0d active cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        logic [NO*DW-1:0] e;
        int bad;
        for (int a = 0; a < 16; a++) mem[a] = DW'(8'h30 + a);
        base_addr = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        n_total++; if (mem_re !== 1'b1) $display("FAIL rml_in_read: got mem_re=%b want 1", mem_re); else n_pass++;
        rst_n = 1'b0;
        step();
        n_total++; if (mem_re !== 1'b0 || busy !== 1'b0 || ops !== '0 || ops_valid !== 1'b0)
                       $display("FAIL rml_cleared: got re=%b busy=%b ops=%h valid=%b want 0/0/0/0", mem_re, busy, ops, ops_valid);
                   else n_pass++;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (ops_valid !== 1'b0 || ops !== '0 || mem_re !== 1'b0) bad++;
            step();
        end
        n_total++; if (bad !== 0) $display("FAIL rml_quiet: got %0d bad cycles want 0", bad); else n_pass++;
        push_expected(4'd3);
        run_load(4'd3);
        e = exp_ops_q.pop_front();
        n_total++; if (lat !== 10 || addr_err !== 0)
                       $display("FAIL rml_reload: got lat=%0d addr_err=%0d want 10/0", lat, addr_err);
                   else n_pass++;
        n_total++; if (ops !== e) $display("FAIL rml_ops: got %h want %h", ops, e); else n_pass++;
        ops_ready = 1'b1;
        step();
        ops_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [NO*DW-1:0] e;
        time t1;
        for (int a = 0; a < 16; a++) mem[a] = DW'(8'h50 + 3*a);
        ops_ready = 1'b1;
        push_expected(4'd8);
        run_load(4'd8);
        t1 = t_start;
        e = exp_ops_q.pop_front();
        n_total++; if (lat !== 10 || addr_err !== 0)
                       $display("FAIL b2b_first: got lat=%0d addr_err=%0d want 10/0", lat, addr_err);
                   else n_pass++;
        n_total++; if (ops !== e) $display("FAIL b2b_ops1: got %h want %h", ops, e); else n_pass++;
        step();
        n_total++; if (busy !== 1'b0 || ops_valid !== 1'b0)
                       $display("FAIL b2b_idle: got busy=%b valid=%b want 0/0", busy, ops_valid);
                   else n_pass++;
        for (int a = 0; a < 16; a++) mem[a] = DW'(8'hC0 ^ a);
        push_expected(4'd1);
        run_load(4'd1);
        e = exp_ops_q.pop_front();
        n_total++; if ((t_start - t1) / 10 !== 11)
                       $display("FAIL b2b_period: got %0d cycles want 11", (t_start - t1) / 10);
                   else n_pass++;
        n_total++; if (lat !== 10 || addr_err !== 0)
                       $display("FAIL b2b_second: got lat=%0d addr_err=%0d want 10/0", lat, addr_err);
                   else n_pass++;
        n_total++; if (ops !== e) $display("FAIL b2b_ops2: got %h want %h", ops, e); else n_pass++;
        step();
        ops_ready = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_strassen_operand_loader
`default_nettype wire
